cpu_sequencer: RTL

//  Synthesizable fetch/decode/execute controller replacing the behavioural CPU sequence.

---
 rtl/cpu_sequencer_pkg.sv | 61 ++++++
 rtl/cpu_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared opcode, ALU-select, skip-condition and FSM state encodings for cpu_sequencer.
// Opcodes live in IR[30:27]; IR[31] is the indirect flag when indirect addressing is built in.
package cpu_sequencer_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_HALT  = 4'd1,
        OP_LOAD  = 4'd2,
        OP_STORE = 4'd3,
        OP_CLEAR = 4'd4,
        OP_SKIP  = 4'd5,
        OP_JUMP  = 4'd6,
        OP_SUB   = 4'd7,
        OP_AND   = 4'd8,
        OP_OR    = 4'd9,
        OP_NOT   = 4'd10
    } opcode_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b100;

    localparam logic [1:0] SKIP_NEG   = 2'b00;
    localparam logic [1:0] SKIP_ZERO  = 2'b01;
    localparam logic [1:0] SKIP_POS   = 2'b10;
    localparam logic [1:0] SKIP_NEVER = 2'b11;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_IR       = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_OPADDR   = 4'd3;
    localparam logic [3:0] S_OPREAD   = 4'd4;
    localparam logic [3:0] S_ALU      = 4'd5;
    localparam logic [3:0] S_WB       = 4'd6;
    localparam logic [3:0] S_STORE    = 4'd7;
    localparam logic [3:0] S_EXEC     = 4'd8;
    localparam logic [3:0] S_HALT     = 4'd9;
    localparam logic [3:0] S_IND_ADDR = 4'd10;
    localparam logic [3:0] S_IND_READ = 4'd11;

    localparam int unsigned CPU_RESET_PC = 32'h100;

    // Opcodes that fetch or store a memory operand through MAR.
    function automatic logic is_mem_op(input opcode_t op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LOAD, OP_STORE: is_mem_op = 1'b1;
            default:                                          is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_sel_for(input opcode_t op);
        case (op)
            OP_SUB:  alu_sel_for = ALU_SUB;
            OP_AND:  alu_sel_for = ALU_AND;
            OP_OR:   alu_sel_for = ALU_OR;
            default: alu_sel_for = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the 32-bit direct-address ISA; drives external sync RAM and ALU.
// Define CPU_INDIRECT_EN to build IR[31] indirect addressing (two extra cycles per indirect operand).
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(CPU_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [2:0]            alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] ac,
    output logic                  halted
);

    logic [3:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [ADDR_WIDTH-1:0] mar_q, mar_d;
    logic [DATA_WIDTH-1:0] mbr_q, mbr_d;
    logic [DATA_WIDTH-1:0] ac_q, ac_d;
    logic [ADDR_WIDTH-1:0] ea_q, ea_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]            alu_sel_q, alu_sel_d;

    opcode_t op;
    logic    skip_taken;
    logic    unused_ir;

    assign op        = opcode_t'(ir_q[30:27]);
    assign unused_ir = ^{ir_q[31], ir_q[26:ADDR_WIDTH]};

    always_comb begin
        skip_taken = 1'b0;
        case (ir_q[11:10])
            SKIP_NEG:  skip_taken = ac_q[DATA_WIDTH-1];
            SKIP_ZERO: skip_taken = (ac_q == '0);
            SKIP_POS:  skip_taken = !ac_q[DATA_WIDTH-1] && (ac_q != '0);
            default:   skip_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mar_d     = mar_q;
        mbr_d     = mbr_q;
        ac_d      = ac_q;
        ea_d      = ea_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        case (state_q)
            S_FETCH: begin
                mar_d   = pc_q[ADDR_WIDTH-1:0];
                state_d = S_IR;
            end
            S_IR: begin
                ir_d    = mem_rdata;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                pc_d = pc_q + DATA_WIDTH'(2);
                ea_d = ir_q[ADDR_WIDTH-1:0];
                if (is_mem_op(op)) begin
                    state_d = S_OPADDR;
                end else begin
                    case (op)
                        OP_CLEAR, OP_NOT, OP_JUMP, OP_SKIP: state_d = S_EXEC;
                        OP_HALT:                            state_d = S_HALT;
                        default:                            state_d = S_FETCH;
                    endcase
                end
`ifdef CPU_INDIRECT_EN
                if (ir_q[31] && (is_mem_op(op) || op == OP_JUMP)) begin
                    state_d = S_IND_ADDR;
                end
`endif
            end
`ifdef CPU_INDIRECT_EN
            S_IND_ADDR: begin
                mar_d   = ea_q;
                state_d = S_IND_READ;
            end
            S_IND_READ: begin
                ea_d    = mem_rdata[ADDR_WIDTH-1:0];
                state_d = (op == OP_JUMP) ? S_EXEC : S_OPADDR;
            end
`endif
            S_OPADDR: begin
                mar_d = ea_q;
                if (op == OP_STORE) begin
                    mbr_d   = ac_q;
                    state_d = S_STORE;
                end else begin
                    state_d = S_OPREAD;
                end
            end
            S_OPREAD: begin
                mbr_d   = mem_rdata;
                state_d = (op == OP_LOAD) ? S_WB : S_ALU;
            end
            S_ALU: begin
                alu_a_d   = ac_q;
                alu_b_d   = mbr_q;
                alu_sel_d = alu_sel_for(op);
                state_d   = S_WB;
            end
            S_WB: begin
                ac_d    = (op == OP_LOAD) ? mbr_q : alu_out;
                state_d = S_FETCH;
            end
            S_STORE: begin
                state_d = S_FETCH;
            end
            S_EXEC: begin
                case (op)
                    OP_CLEAR: ac_d = '0;
                    OP_NOT:   ac_d = ~ac_q;
                    OP_JUMP:  pc_d = DATA_WIDTH'(ea_q);
                    OP_SKIP:  if (skip_taken) pc_d = pc_q + DATA_WIDTH'(2);
                    default:  ac_d = ac_q;
                endcase
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            mar_q     <= '0;
            mbr_q     <= '0;
            ac_q      <= '0;
            ea_q      <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= ALU_AND;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mar_q     <= mar_d;
            mbr_q     <= mbr_d;
            ac_q      <= ac_d;
            ea_q      <= ea_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
        end
    end

    // The RAM registers its address on the same edge that loads MAR, so it is fed MAR's
    // incoming value; read data then arrives the cycle after each address state.
    assign mem_addr  = mar_d;
    assign mem_cs    = !rst && (state_q != S_HALT);
    assign mem_we    = !rst && (state_q == S_STORE);
    assign mem_oe    = !mem_we;
    assign mem_wdata = mbr_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign pc        = pc_q;
    assign ac        = ac_q;
    assign halted    = (state_q == S_HALT);

endmodule
